// File: rtl/resp_sched.sv
// -----------------------------------------------------------------------------
// resp_sched
// Merges single-character echoes and multi-character command responses into
// one character-FIFO write stream. A pending echo always wins the write slot.
// Responses are "-OK", "-ERR" or "-" + 4 hex digits, each followed by CR
// and, when SEND_LF=1, LF.
//
// Ports
//   clk_rx          : clock, all state on its rising edge
//   rst_clk_rx      : synchronous active-high reset
//   send_char_val   : one-cycle echo strobe, send_char is the echo byte
//   send_resp_val   : response request, held until send_resp_done
//   send_resp_type  : 00 OK, 01 ERR, 10 DATA, 11 ERR
//   send_resp_data  : value printed by DATA responses
//   send_resp_done  : one-cycle pulse when the last response byte is written
//   char_fifo_full  : FIFO cannot take a write; sampled in the decision cycle
//   char_fifo_din   : registered write data
//   char_fifo_wr_en : registered write strobe, issued only for a slot decided
//                     while char_fifo_full was low
//   echo_drop       : one-cycle pulse when a pending echo was overwritten
// -----------------------------------------------------------------------------
module resp_sched #(
    parameter int SEND_LF = 1
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic        send_char_val,
    input  logic [7:0]  send_char,
    input  logic        send_resp_val,
    input  logic [1:0]  send_resp_type,
    input  logic [15:0] send_resp_data,
    output logic        send_resp_done,
    input  logic        char_fifo_full,
    output logic [7:0]  char_fifo_din,
    output logic        char_fifo_wr_en,
    output logic        echo_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] v;
        if (nib < 4'd10) begin
            v = 8'h30 + {4'h0, nib};
        end else begin
            v = 8'h37 + {4'h0, nib};
        end
        return v;
    endfunction

    // Index of the final character of a response (the CR when LF is off).
    function automatic logic [2:0] last_idx(input logic [1:0] typ);
        logic [2:0] v;
        case (typ)
            2'b00:   v = 3'd4;
            2'b10:   v = 3'd6;
            default: v = 3'd5;
        endcase
        if (SEND_LF == 0) begin
            v = v - 3'd1;
        end else begin
            v = v;
        end
        return v;
    endfunction

    // Character at position idx of the response selected by typ.
    function automatic logic [7:0] resp_char(input logic [1:0] typ,
                                             input logic [15:0] data,
                                             input logic [2:0] idx);
        logic [7:0] v;
        case (typ)
            2'b00: begin
                case (idx)
                    3'd0:    v = CH_DASH;
                    3'd1:    v = 8'h4F;
                    3'd2:    v = 8'h4B;
                    3'd3:    v = CH_CR;
                    default: v = CH_LF;
                endcase
            end
            2'b10: begin
                case (idx)
                    3'd0:    v = CH_DASH;
                    3'd1:    v = hex_ascii(data[15:12]);
                    3'd2:    v = hex_ascii(data[11:8]);
                    3'd3:    v = hex_ascii(data[7:4]);
                    3'd4:    v = hex_ascii(data[3:0]);
                    3'd5:    v = CH_CR;
                    default: v = CH_LF;
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    v = CH_DASH;
                    3'd1:    v = 8'h45;
                    3'd2:    v = 8'h52;
                    3'd3:    v = 8'h52;
                    3'd4:    v = CH_CR;
                    default: v = CH_LF;
                endcase
            end
        endcase
        return v;
    endfunction

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [1:0]  r_type;
    logic [15:0] r_data;
    logic        r_echo_pend;
    logic [7:0]  r_echo_char;
    logic        r_wr_en;
    logic [7:0]  r_din;
    logic        r_done;
    logic        r_drop;

    state_t      w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic        w_load;
    logic        w_wr_echo;
    logic        w_wr_resp;
    logic        w_resp_last;
    logic [7:0]  w_resp_char;

    // Slot arbitration and FSM next-state / index update.
    always_comb begin
        w_wr_echo   = r_echo_pend & ~char_fifo_full;
        w_wr_resp   = (r_state == ST_SEND) & ~char_fifo_full & ~r_echo_pend;
        w_resp_last = (r_idx == last_idx(r_type));
        w_resp_char = resp_char(r_type, r_data, r_idx);
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_resp_val) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = 3'd0;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_wr_resp) begin
                    w_idx_nxt = r_idx + 3'd1;
                    if (w_resp_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state and response index registers.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Request capture; type/data are frozen for the whole response.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_type <= 2'b00;
            r_data <= 16'h0000;
        end else if (w_load) begin
            r_type <= send_resp_type;
            r_data <= send_resp_data;
        end else begin
            r_type <= r_type;
            r_data <= r_data;
        end
    end

    // One-entry echo buffer. A new echo only counts as a drop when the
    // pending one is not leaving through the write slot this same cycle.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_echo_pend <= 1'b0;
            r_echo_char <= 8'h00;
            r_drop      <= 1'b0;
        end else if (send_char_val) begin
            r_echo_pend <= 1'b1;
            r_echo_char <= send_char;
            r_drop      <= r_echo_pend & ~w_wr_echo;
        end else begin
            r_echo_pend <= r_echo_pend & ~w_wr_echo;
            r_echo_char <= r_echo_char;
            r_drop      <= 1'b0;
        end
    end

    // Registered FIFO write port and done pulse.
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_wr_en <= 1'b0;
            r_din   <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_wr_en <= w_wr_echo | w_wr_resp;
            if (w_wr_echo) begin
                r_din <= r_echo_char;
            end else if (w_wr_resp) begin
                r_din <= w_resp_char;
            end else begin
                r_din <= r_din;
            end
            r_done <= w_wr_resp & w_resp_last;
        end
    end

    assign char_fifo_wr_en = r_wr_en;
    assign char_fifo_din   = r_din;
    assign send_resp_done  = r_done;
    assign echo_drop       = r_drop;

endmodule

// File: tb/tb_resp_sched.sv
// -----------------------------------------------------------------------------
// tb_resp_sched
// Self-checking bench for resp_sched. Two instances share stimulus: dut with
// SEND_LF=1 and dut0 with SEND_LF=0 (dut0 gets its own request strobe).
// A negedge monitor logs every FIFO write, done and drop pulse with its cycle
// number; expected strings come from a small text model of the responses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_resp_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, char_val, resp_val, resp_val0, full;
    logic [7:0]  chr;
    logic [1:0]  rtype;
    logic [15:0] rdata;
    logic        done, wr_en, drop, done0, wr_en0, drop0;
    logic [7:0]  din, din0;

    resp_sched #(.SEND_LF(1)) dut (
        .clk_rx(clk), .rst_clk_rx(rst), .send_char_val(char_val), .send_char(chr),
        .send_resp_val(resp_val), .send_resp_type(rtype), .send_resp_data(rdata),
        .send_resp_done(done), .char_fifo_full(full), .char_fifo_din(din),
        .char_fifo_wr_en(wr_en), .echo_drop(drop)
    );

    resp_sched #(.SEND_LF(0)) dut0 (
        .clk_rx(clk), .rst_clk_rx(rst), .send_char_val(char_val), .send_char(chr),
        .send_resp_val(resp_val0), .send_resp_type(rtype), .send_resp_data(rdata),
        .send_resp_done(done0), .char_fifo_full(full), .char_fifo_din(din0),
        .char_fifo_wr_en(wr_en0), .echo_drop(drop0)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    logic full_q = 1'b0;

    int          wr_cyc[$];
    logic [7:0]  wr_chr[$];
    int          done_cyc[$];
    int          drop_cyc[$];
    logic [7:0]  wr0_chr[$];
    int          done0_cyc[$];
    logic [7:0]  exp_q[$];

    // Cycle counter and the full value seen at each decision edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_q <= full;
    end

    // Monitor: a write is only legal for a slot decided while full was low.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_chr.push_back(din);
        end
        if (wr_en0 === 1'b1) wr0_chr.push_back(din0);
        viol <= viol + (((wr_en === 1'b1) && (full_q === 1'b1)) ? 1 : 0)
                     + (((wr_en0 === 1'b1) && (full_q === 1'b1)) ? 1 : 0);
        if (done === 1'b1)  done_cyc.push_back(cyc);
        if (done0 === 1'b1) done0_cyc.push_back(cyc);
        if (drop === 1'b1)  drop_cyc.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc = {};
        wr_chr = {};
        done_cyc = {};
        drop_cyc = {};
        wr0_chr = {};
        done0_cyc = {};
        viol = 0;
    endtask

    // Reference text of a response, built from the response rules.
    task automatic make_expected(input logic [1:0] t, input logic [15:0] d, input bit lf);
        int nib;
        exp_q = {};
        exp_q.push_back(8'h2D);
        if (t == 2'b00) begin
            exp_q.push_back(8'h4F);
            exp_q.push_back(8'h4B);
        end else if (t == 2'b10) begin
            for (int k = 3; k >= 0; k--) begin
                nib = (int'(d) >> (4 * k)) % 16;
                exp_q.push_back(8'((nib < 10) ? (48 + nib) : (55 + nib)));
            end
        end else begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h52);
            exp_q.push_back(8'h52);
        end
        exp_q.push_back(8'h0D);
        if (lf) exp_q.push_back(8'h0A);
    endtask

    // Drives one response request until its done pulse (bounded), then drains.
    task automatic do_resp(input logic [1:0] t, input logic [15:0] d, input bit use0,
                           input bit rand_full, input bit mutate, input int echo_off,
                           input logic [7:0] echo_c, output int s);
        bit got;
        got = 1'b0;
        step();
        rtype = t;
        rdata = d;
        if (use0) resp_val0 = 1'b1;
        else resp_val = 1'b1;
        s = cyc;
        for (int k = 0; k < 300 && !got; k++) begin
            step();
            char_val = (echo_off > 0) && (cyc == s + echo_off);
            chr = echo_c;
            if (mutate) begin
                rtype = 2'($urandom);
                rdata = 16'($urandom);
            end
            if (rand_full) full = ($urandom_range(0, 2) == 0);
            got = use0 ? (done0_cyc.size() > 0) : (done_cyc.size() > 0);
        end
        resp_val = 1'b0;
        resp_val0 = 1'b0;
        full = 1'b0;
        char_val = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL resp_timeout: done seen=%0d required=1", got);
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        char_val = 1'($urandom);
        chr = 8'($urandom);
        resp_val = 1'($urandom);
        resp_val0 = 1'b0;
        rtype = 2'($urandom);
        rdata = 16'($urandom);
        full = 1'($urandom);
        step();
        step();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got=%b exp=0", wr_en); end
        checks++; if (din !== 8'h00) begin failures++; $display("FAIL reset_din: got=%h exp=00", din); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got=%b exp=0", done); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got=%b exp=0", drop); end
        rst = 1'b0;
        char_val = 1'b0;
        resp_val = 1'b0;
        full = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_echo();
        int e;
        logic [7:0] c;
        for (int i = 0; i < 9; i++) begin
            clear_logs();
            c = (i == 0) ? 8'h41 : 8'($urandom);
            step();
            char_val = 1'b1;
            chr = c;
            e = cyc;
            step();
            char_val = 1'b0;
            chr = 8'($urandom);
            repeat (2 + $urandom_range(0, 3)) step();
            checks++;
            if (wr_chr.size() != 1 || wr_chr[0] !== c || wr_cyc[0] != e + 2) begin
                failures++;
                $display("FAIL echo_%0d: writes=%0d chr=%h cyc=%0d exp 1 write chr=%h cyc=%0d",
                         i, wr_chr.size(), wr_chr[0], wr_cyc[0], c, e + 2);
            end
        end
    endtask

    task automatic test_ok();
        int s;
        logic [15:0] d;
        clear_logs();
        d = 16'($urandom);
        do_resp(2'b00, d, 1'b0, 1'b0, 1'b0, 0, 8'h00, s);
        make_expected(2'b00, d, 1'b1);
        checks++;
        if (wr_chr.size() != 5) begin failures++; $display("FAIL ok_len: got=%0d exp=5", wr_chr.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_chr.size(); k++) begin
            checks++;
            if (wr_chr[k] !== exp_q[k] || wr_cyc[k] != s + 2 + k) begin
                failures++;
                $display("FAIL ok_char%0d: got=%h@%0d exp=%h@%0d", k, wr_chr[k], wr_cyc[k], exp_q[k], s + 2 + k);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 6) begin
            failures++;
            $display("FAIL ok_done: count=%0d cyc=%0d exp count=1 cyc=%0d", done_cyc.size(), done_cyc[0], s + 6);
        end
    endtask

    task automatic test_data();
        int s;
        clear_logs();
        do_resp(2'b10, 16'h3A0F, 1'b0, 1'b0, 1'b0, 0, 8'h00, s);
        make_expected(2'b10, 16'h3A0F, 1'b1);
        checks++;
        if (wr_chr != exp_q) begin
            failures++;
            $display("FAIL data_lf1: got=%p exp=%p", wr_chr, exp_q);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 8) begin
            failures++;
            $display("FAIL data_done: count=%0d cyc=%0d exp count=1 cyc=%0d", done_cyc.size(), done_cyc[0], s + 8);
        end
        clear_logs();
        do_resp(2'b10, 16'h3A0F, 1'b1, 1'b0, 1'b0, 0, 8'h00, s);
        make_expected(2'b10, 16'h3A0F, 1'b0);
        checks++;
        if (wr0_chr != exp_q || done0_cyc.size() != 1) begin
            failures++;
            $display("FAIL data_lf0: got=%p dones=%0d exp=%p dones=1", wr0_chr, done0_cyc.size(), exp_q);
        end
    endtask

    task automatic test_random();
        int s;
        logic [1:0] t;
        logic [15:0] d;
        bit use0;
        logic [7:0] got_q[$];
        for (int i = 0; i < 20; i++) begin
            clear_logs();
            t = 2'($urandom);
            d = 16'($urandom);
            use0 = (i % 3 == 2);
            do_resp(t, d, use0, 1'b1, 1'b1, 0, 8'h00, s);
            make_expected(t, d, !use0);
            got_q = use0 ? wr0_chr : wr_chr;
            checks++;
            if (got_q != exp_q || viol != 0) begin
                failures++;
                $display("FAIL rand_%0d type=%b data=%h: got=%p viol=%0d exp=%p viol=0", i, t, d, got_q, viol, exp_q);
            end
            if (!use0) begin
                checks++;
                if (done_cyc.size() != 1 || wr_cyc.size() == 0 || done_cyc[0] != wr_cyc[wr_cyc.size() - 1]) begin
                    failures++;
                    $display("FAIL rand_done_%0d: dones=%0d cyc=%0d exp 1 at last write", i, done_cyc.size(), done_cyc[0]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int s;
        bit got;
        clear_logs();
        got = 1'b0;
        step();
        rtype = 2'b01;
        rdata = 16'($urandom);
        resp_val = 1'b1;
        s = cyc;
        for (int k = 0; k < 60 && !got; k++) begin
            step();
            full = (cyc >= s + 4) && (cyc <= s + 6);
            got = (done_cyc.size() > 0);
        end
        resp_val = 1'b0;
        full = 1'b0;
        repeat (6) step();
        make_expected(2'b01, 16'h0000, 1'b1);
        checks++;
        if (wr_chr != exp_q || done_cyc.size() != 1) begin
            failures++;
            $display("FAIL bp_seq: got=%p dones=%0d exp=%p dones=1", wr_chr, done_cyc.size(), exp_q);
        end
        checks++;
        if (wr_cyc.size() < 4 || wr_cyc[2] != s + 4 || wr_cyc[3] != s + 8) begin
            failures++;
            $display("FAIL bp_stall: cyc2=%0d cyc3=%0d exp %0d %0d", wr_cyc[2], wr_cyc[3], s + 4, s + 8);
        end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL bp_wr_while_full: got=%0d exp=0", viol); end
    endtask

    task automatic test_collision();
        int s;
        int off;
        int m;
        bit found;
        logic [15:0] d;
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            off = i + 1;
            d = 16'($urandom);
            do_resp(2'b00, d, 1'b0, 1'b0, 1'b0, off, 8'h57, s);
            make_expected(2'b00, d, 1'b1);
            m = 0;
            found = 1'b0;
            for (int k = 0; k < wr_chr.size(); k++) begin
                if (wr_cyc[k] == s + off + 2) begin
                    found = (wr_chr[k] === 8'h57);
                end else begin
                    checks++;
                    if (m >= exp_q.size() || wr_chr[k] !== exp_q[m]) begin
                        failures++;
                        $display("FAIL coll_%0d_char%0d: got=%h exp=%h", i, m, wr_chr[k], exp_q[m]);
                    end
                    m++;
                end
            end
            checks++;
            if (!found || m != 5 || wr_chr.size() != 6 || done_cyc.size() != 1) begin
                failures++;
                $display("FAIL coll_%0d: echo_ok=%0d resp=%0d writes=%0d dones=%0d exp 1 5 6 1",
                         i, found, m, wr_chr.size(), done_cyc.size());
            end
        end
    endtask

    task automatic test_overwrite();
        int a;
        int b;
        clear_logs();
        step();
        full = 1'b1;
        step();
        char_val = 1'b1;
        chr = 8'h31;
        a = cyc;
        step();
        char_val = 1'b0;
        step();
        char_val = 1'b1;
        chr = 8'h32;
        step();
        char_val = 1'b0;
        step();
        step();
        full = 1'b0;
        repeat (6) step();
        checks++;
        if (drop_cyc.size() != 1 || drop_cyc[0] != a + 3) begin
            failures++;
            $display("FAIL ow_drop: count=%0d cyc=%0d exp count=1 cyc=%0d", drop_cyc.size(), drop_cyc[0], a + 3);
        end
        checks++;
        if (wr_chr.size() != 1 || wr_chr[0] !== 8'h32 || wr_cyc[0] != a + 6 || viol != 0) begin
            failures++;
            $display("FAIL ow_write: writes=%0d chr=%h cyc=%0d viol=%0d exp 1 32 %0d 0",
                     wr_chr.size(), wr_chr[0], wr_cyc[0], viol, a + 6);
        end
        clear_logs();
        step();
        char_val = 1'b1;
        chr = 8'h61;
        b = cyc;
        step();
        chr = 8'h62;
        step();
        char_val = 1'b0;
        repeat (5) step();
        checks++;
        if (drop_cyc.size() != 0 || wr_chr.size() != 2 || wr_chr[0] !== 8'h61 || wr_chr[1] !== 8'h62 ||
            wr_cyc[0] != b + 2 || wr_cyc[1] != b + 3) begin
            failures++;
            $display("FAIL echo_pair: drops=%0d writes=%0d chr=%h,%h exp 0 2 61,62", drop_cyc.size(),
                     wr_chr.size(), wr_chr[0], wr_chr[1]);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        bit got;
        logic [15:0] d;
        clear_logs();
        got = 1'b0;
        d = 16'($urandom);
        step();
        rtype = 2'b10;
        rdata = d;
        resp_val = 1'b1;
        s = cyc;
        for (int k = 0; k < 100 && !got; k++) begin
            step();
            got = (done_cyc.size() >= 2);
        end
        resp_val = 1'b0;
        repeat (8) step();
        make_expected(2'b10, d, 1'b1);
        exp_q = {exp_q, exp_q};
        checks++;
        if (wr_chr != exp_q) begin failures++; $display("FAIL b2b_seq: got=%p exp=%p", wr_chr, exp_q); end
        checks++;
        if (done_cyc.size() != 2 || done_cyc[0] != s + 8 || done_cyc[1] != s + 17 ||
            wr_cyc.size() != 14 || wr_cyc[7] != s + 11) begin
            failures++;
            $display("FAIL b2b_timing: dones=%0d d0=%0d d1=%0d restart=%0d exp 2 %0d %0d %0d",
                     done_cyc.size(), done_cyc[0], done_cyc[1], wr_cyc[7], s + 8, s + 17, s + 11);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        int late;
        clear_logs();
        step();
        rtype = 2'b10;
        rdata = 16'($urandom);
        resp_val = 1'b1;
        s = cyc;
        repeat (3) step();
        rst = 1'b1;
        resp_val = 1'b0;
        step();
        checks++;
        if (wr_en !== 1'b0 || din !== 8'h00 || done !== 1'b0 || drop !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: wr_en=%b din=%h done=%b drop=%b exp 0 00 0 0", wr_en, din, done, drop);
        end
        rst = 1'b0;
        repeat (12) step();
        late = 0;
        foreach (wr_cyc[k]) if (wr_cyc[k] >= s + 4) late++;
        checks++;
        if (late != 0 || wr_cyc.size() != 2 || done_cyc.size() != 0) begin
            failures++;
            $display("FAIL rstmid_abandon: late=%0d writes=%0d dones=%0d exp 0 2 0", late, wr_cyc.size(), done_cyc.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        char_val = 1'b0;
        chr = 8'h00;
        resp_val = 1'b0;
        resp_val0 = 1'b0;
        rtype = 2'b00;
        rdata = 16'h0000;
        full = 1'b0;
        test_reset();
        test_echo();
        test_ok();
        test_data();
        test_random();
        test_backpressure();
        test_collision();
        test_overwrite();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
